// File: rtl/mem_responder.sv
// Memory-side responder for the CPU mem interface: fixed-latency word reads and byte-masked writes, sticky error reporting.
// Optional MEM_RAND_LATENCY_EN adds an LFSR-driven 0..3 cycle latency jitter per accepted request.
module mem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h1ECE_B000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [3:0]  mem_wmask,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_resp,
  output logic        err_sticky,
  output logic [1:0]  err_cause
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
`ifdef MEM_RAND_LATENCY_EN
  localparam int unsigned CW = 5;
`else
  localparam int unsigned CW = 4;
`endif

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [31:0]     lat_addr;
  logic [31:0]     lat_wdata;
  logic [3:0]      lat_wmask;
  logic            lat_read;
  logic            lat_write;
  logic [31:0]     mem [DEPTH_WORDS];

  logic [31:0]     cur_addr;
  logic [31:0]     cur_wdata;
  logic [3:0]      cur_wmask;
  logic            cur_read;
  logic            cur_write;
  logic            accept;
  logic            both_req;
  logic [CW-1:0]   eff_lat;
  logic [CW-1:0]   load_cnt;
  logic            commit;
  logic            proto_err;
  logic [31:0]     idx_full;
  logic [AW-1:0]   idx;
  logic            misaligned;
  logic            in_range;
  logic            addr_ok;
  logic            wr_en;

`ifdef MEM_RAND_LATENCY_EN
  logic [7:0]      lfsr;
  logic            lfsr_fb;
  assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
`endif

  // In IDLE the request is being latched this edge, so the live inputs equal the latched view.
  always_comb begin
    cur_addr  = lat_addr;
    cur_wdata = lat_wdata;
    cur_wmask = lat_wmask;
    cur_read  = lat_read;
    cur_write = lat_write;
    if (state == IDLE) begin
      cur_addr  = mem_addr;
      cur_wdata = mem_wdata;
      cur_wmask = mem_wmask;
      cur_read  = mem_read;
      cur_write = mem_write;
    end
  end

  always_comb begin
    both_req = (state == IDLE) && mem_read && mem_write;
    accept   = (state == IDLE) && (mem_read ^ mem_write);
`ifdef MEM_RAND_LATENCY_EN
    eff_lat  = CW'(LATENCY) + CW'(lfsr[1:0]);
`else
    eff_lat  = CW'(LATENCY);
`endif
    load_cnt  = eff_lat - CW'(1);
    commit    = (accept && (load_cnt == '0)) || ((state == BUSY) && (cnt == CW'(1)));
    proto_err = (state == BUSY) &&
                ((mem_addr != lat_addr) || (mem_read != lat_read) || (mem_write != lat_write));
  end

  // Address below BASE_ADDR wraps to a huge index and fails the range test.
  always_comb begin
    idx_full   = (cur_addr - BASE_ADDR) >> 2;
    idx        = idx_full[AW-1:0];
    misaligned = (cur_addr[1:0] != 2'b00);
    in_range   = (idx_full < DEPTH_WORDS);
    addr_ok    = in_range && !misaligned;
    wr_en      = commit && cur_write && addr_ok && !rst;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (cur_wmask[i]) mem[idx][8*i +: 8] <= cur_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_wmask  <= '0;
      lat_read   <= 1'b0;
      lat_write  <= 1'b0;
      mem_resp   <= 1'b0;
      mem_rdata  <= '0;
      err_sticky <= 1'b0;
      err_cause  <= 2'b00;
`ifdef MEM_RAND_LATENCY_EN
      lfsr       <= 8'hA5;
`endif
    end else begin
      mem_resp <= 1'b0;
      case (state)
        IDLE: begin
          if (both_req) begin
            err_sticky <= 1'b1;
            err_cause  <= 2'b11;
          end else if (accept) begin
            lat_addr  <= mem_addr;
            lat_wdata <= mem_wdata;
            lat_wmask <= mem_wmask;
            lat_read  <= mem_read;
            lat_write <= mem_write;
            cnt       <= load_cnt;
`ifdef MEM_RAND_LATENCY_EN
            lfsr      <= {lfsr[6:0], lfsr_fb};
`endif
            state     <= (load_cnt == '0) ? RESP : BUSY;
          end
        end
        BUSY: begin
          cnt <= cnt - CW'(1);
          if (proto_err) begin
            err_sticky <= 1'b1;
            err_cause  <= 2'b11;
          end
          if (cnt == CW'(1)) state <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase

      // Completion edge; an address error here overrides a same-edge protocol error.
      if (commit) begin
        mem_resp <= 1'b1;
        if (misaligned) begin
          mem_rdata  <= '0;
          err_sticky <= 1'b1;
          err_cause  <= 2'b01;
        end else if (!in_range) begin
          mem_rdata  <= '0;
          err_sticky <= 1'b1;
          err_cause  <= 2'b10;
        end else if (cur_read) begin
          mem_rdata <= mem[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder; tracks the random-latency LFSR when MEM_RAND_LATENCY_EN is defined.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] mem_addr = '0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [3:0]  mem_wmask = '0;
  logic [31:0] mem_wdata = '0;
  logic [31:0] mem_rdata;
  logic        mem_resp;
  logic        err_sticky;
  logic [1:0]  err_cause;

  int checks = 0;
  int failures = 0;
  logic [7:0] m_lfsr = 8'hA5;

  always #5 clk = ~clk;

  mem_responder #(
    .BASE_ADDR  (32'h1ECE_B000),
    .DEPTH_WORDS(1024),
    .LATENCY    (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_addr  (mem_addr),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_wmask (mem_wmask),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_resp  (mem_resp),
    .err_sticky(err_sticky),
    .err_cause (err_cause)
  );

  // Expected latency of the next accepted request; advances the reference LFSR.
  function automatic int exp_lat();
`ifdef MEM_RAND_LATENCY_EN
    int l;
    l = 3 + int'(m_lfsr[1:0]);
    m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    return l;
`else
    return 3;
`endif
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    m_lfsr = 8'hA5;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Issues one request, returns latency in cycles (0 on timeout), rdata in resp cycle, and resp one cycle later.
  task automatic do_req(input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] m, output logic [31:0] rd, output int lat,
                        output logic resp_after);
    mem_addr = a; mem_wdata = d; mem_wmask = m;
    mem_read = !wr; mem_write = wr;
    lat = 0; rd = '0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (mem_resp) begin
        lat = c; rd = mem_rdata;
        break;
      end
    end
    mem_read = 1'b0; mem_write = 1'b0;
    @(posedge clk); #1;
    resp_after = mem_resp;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (mem_resp !== 1'b0) begin failures++; $display("FAIL reset_resp got=%b exp=0", mem_resp); end
    checks++; if (mem_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", mem_rdata); end
    checks++; if (err_sticky !== 1'b0) begin failures++; $display("FAIL reset_sticky got=%b exp=0", err_sticky); end
    checks++; if (err_cause !== 2'b00) begin failures++; $display("FAIL reset_cause got=%b exp=00", err_cause); end
  endtask

  task automatic test_write_read();
    logic [31:0] rd; int lat; int el; logic ra;
    el = exp_lat();
    do_req(1'b1, 32'h1ECE_B004, 32'hDEAD_BEEF, 4'b1111, rd, lat, ra);
    checks++; if (lat !== el) begin failures++; $display("FAIL wr_latency got=%0d exp=%0d", lat, el); end
    checks++; if (ra !== 1'b0) begin failures++; $display("FAIL wr_resp_pulse got=%b exp=0", ra); end
    el = exp_lat();
    do_req(1'b0, 32'h1ECE_B004, 32'h0, 4'b0000, rd, lat, ra);
    checks++; if (lat !== el) begin failures++; $display("FAIL rd_latency got=%0d exp=%0d", lat, el); end
    checks++; if (rd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rd_data got=%h exp=deadbeef", rd); end
    checks++; if (mem_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rd_hold got=%h exp=deadbeef", mem_rdata); end
    checks++; if (err_sticky !== 1'b0) begin failures++; $display("FAIL rd_sticky got=%b exp=0", err_sticky); end
  endtask

  task automatic test_byte_mask();
    logic [31:0] rd; int lat; logic ra;
    void'(exp_lat());
    do_req(1'b1, 32'h1ECE_B004, 32'h0000_AB00, 4'b0010, rd, lat, ra);
    void'(exp_lat());
    do_req(1'b0, 32'h1ECE_B004, 32'h0, 4'b1111, rd, lat, ra);
    checks++; if (rd !== 32'hDEAD_ABEF) begin failures++; $display("FAIL mask_byte1 got=%h exp=deadabef", rd); end
    void'(exp_lat());
    do_req(1'b1, 32'h1ECE_B004, 32'h1111_1111, 4'b0000, rd, lat, ra);
    checks++; if (lat == 0) begin failures++; $display("FAIL mask_none_resp got=timeout exp=resp"); end
    void'(exp_lat());
    do_req(1'b0, 32'h1ECE_B004, 32'h0, 4'b0000, rd, lat, ra);
    checks++; if (rd !== 32'hDEAD_ABEF) begin failures++; $display("FAIL mask_none got=%h exp=deadabef", rd); end
  endtask

  task automatic test_misaligned();
    logic [31:0] rd; int lat; int el; logic ra;
    el = exp_lat();
    do_req(1'b0, 32'h1ECE_B002, 32'h0, 4'b0000, rd, lat, ra);
    checks++; if (lat !== el) begin failures++; $display("FAIL mis_latency got=%0d exp=%0d", lat, el); end
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL mis_rdata got=%h exp=0", rd); end
    checks++; if (err_sticky !== 1'b1) begin failures++; $display("FAIL mis_sticky got=%b exp=1", err_sticky); end
    checks++; if (err_cause !== 2'b01) begin failures++; $display("FAIL mis_cause got=%b exp=01", err_cause); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd; int lat; logic ra;
    void'(exp_lat());
    do_req(1'b1, 32'h1ECE_BFFC, 32'h5A5A_0001, 4'b1111, rd, lat, ra);
    void'(exp_lat());
    do_req(1'b0, 32'h1ECE_BFFC, 32'h0, 4'b0000, rd, lat, ra);
    checks++; if (rd !== 32'h5A5A_0001) begin failures++; $display("FAIL last_word got=%h exp=5a5a0001", rd); end
    void'(exp_lat());
    do_req(1'b0, 32'h1ECE_C000, 32'h0, 4'b0000, rd, lat, ra);
    checks++; if (lat == 0) begin failures++; $display("FAIL oob_resp got=timeout exp=resp"); end
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL oob_rdata got=%h exp=0", rd); end
    checks++; if (err_cause !== 2'b10) begin failures++; $display("FAIL oob_cause got=%b exp=10", err_cause); end
    void'(exp_lat());
    do_req(1'b1, 32'h1ECE_AFFC, 32'hFFFF_FFFF, 4'b1111, rd, lat, ra);
    checks++; if (err_cause !== 2'b10) begin failures++; $display("FAIL below_cause got=%b exp=10", err_cause); end
    void'(exp_lat());
    do_req(1'b0, 32'h1ECE_BFFC, 32'h0, 4'b0000, rd, lat, ra);
    checks++; if (rd !== 32'h5A5A_0001) begin failures++; $display("FAIL below_nowrite got=%h exp=5a5a0001", rd); end
    checks++; if (err_cause !== 2'b10) begin failures++; $display("FAIL cause_kept got=%b exp=10", err_cause); end
    void'(exp_lat());
    do_req(1'b0, 32'h1ECE_C001, 32'h0, 4'b0000, rd, lat, ra);
    checks++; if (err_cause !== 2'b01) begin failures++; $display("FAIL mis_wins got=%b exp=01", err_cause); end
  endtask

  task automatic test_protocol();
    int seen = 0;
    do_reset();
    mem_addr = 32'h1ECE_B004; mem_read = 1'b1; mem_write = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (mem_resp) seen++;
    end
    mem_read = 1'b0; mem_write = 1'b0;
    @(posedge clk); #1;
    checks++; if (seen != 0) begin failures++; $display("FAIL proto_noresp got=%0d exp=0", seen); end
    checks++; if (err_cause !== 2'b11) begin failures++; $display("FAIL proto_cause got=%b exp=11", err_cause); end
    checks++; if (err_sticky !== 1'b1) begin failures++; $display("FAIL proto_sticky got=%b exp=1", err_sticky); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; int lat; logic ra; int seen = 0;
    void'(exp_lat());
    mem_addr = 32'h1ECE_B004; mem_wdata = 32'h1234_5678; mem_wmask = 4'b1111; mem_write = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; m_lfsr = 8'hA5; mem_write = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (mem_resp) seen++;
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL rstmid_noresp got=%0d exp=0", seen); end
    checks++; if (err_sticky !== 1'b0) begin failures++; $display("FAIL rstmid_sticky got=%b exp=0", err_sticky); end
    void'(exp_lat());
    do_req(1'b0, 32'h1ECE_B004, 32'h0, 4'b0000, rd, lat, ra);
    checks++; if (rd !== 32'hDEAD_ABEF) begin failures++; $display("FAIL rstmid_nowrite got=%h exp=deadabef", rd); end
  endtask

  task automatic test_busy_change();
    logic [31:0] rd; int lat = 0; int el; logic ra;
    el = exp_lat();
    mem_addr = 32'h1ECE_B008; mem_wdata = 32'hCAFE_F00D; mem_wmask = 4'b1111; mem_write = 1'b1;
    @(posedge clk); #1;
    mem_addr = 32'h1ECE_B00C;
    for (int c = 2; c <= 40; c++) begin
      @(posedge clk); #1;
      if (mem_resp) begin lat = c; break; end
    end
    mem_write = 1'b0;
    @(posedge clk); #1;
    checks++; if (lat !== el) begin failures++; $display("FAIL chg_latency got=%0d exp=%0d", lat, el); end
    checks++; if (err_cause !== 2'b11) begin failures++; $display("FAIL chg_cause got=%b exp=11", err_cause); end
    void'(exp_lat());
    do_req(1'b0, 32'h1ECE_B008, 32'h0, 4'b0000, rd, lat, ra);
    checks++; if (rd !== 32'hCAFE_F00D) begin failures++; $display("FAIL chg_latched got=%h exp=cafef00d", rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; int lat; int el; logic ra;
    do_reset();
    for (int n = 0; n < 8; n++) begin
      el = exp_lat();
      do_req(1'b0, 32'h1ECE_B004, 32'h0, 4'b0000, rd, lat, ra);
      checks++; if (lat !== el) begin failures++; $display("FAIL b2b_latency[%0d] got=%0d exp=%0d", n, lat, el); end
      checks++; if (lat < 3 || lat > 6) begin failures++; $display("FAIL b2b_range[%0d] got=%0d exp=3..6", n, lat); end
      checks++; if (rd !== 32'hDEAD_ABEF) begin failures++; $display("FAIL b2b_data[%0d] got=%h exp=deadabef", n, rd); end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_mask();
    test_misaligned();
    test_out_of_range();
    test_protocol();
    test_reset_mid();
    test_busy_change();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
